motor_mixer: RTL and testbench

Quad-X motor mixer sitting directly upstream of the four per-motor PWM ramp stages. It accepts one flight command (throttle plus signed roll/pitch/yaw corrections) through a valid/ready handshake. It computes the four motor speeds sequentially with one shared adder, clamps each to the legal speed range, and delivers each result to its PWM stage. Delivery uses that stage's `speed_oe`/`busy` protocol: a one-cycle load strobe, issued only while the stage is idle.

---
 rtl/motor_pkg.sv | 28 ++
 rtl/motor_dispatch.sv | 43 ++++
 rtl/motor_mixer.sv | 153 +++++++++++++++
 tb/tb_motor_mixer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared constants, mix sign table and FSM state type for the
// quad-X motor mixer.
package motor_pkg;

    localparam int NUM_MOTORS = 4;
    localparam int MIX_W      = 19;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    // bit0 roll, bit1 pitch, bit2 yaw; a set bit subtracts that term
    localparam logic [2:0] MIX_NEG [NUM_MOTORS] = '{
        3'b100,
        3'b001,
        3'b111,
        3'b010
    };

    function automatic logic signed [MIX_W-1:0] mix_term(
        input logic signed [MIX_W-1:0] v,
        input logic                    neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/motor_dispatch.sv
// One motor channel: latest-wins speed register, pending flag and
// a guarded one-cycle load strobe toward the PWM stage.
module motor_dispatch #(
    parameter int MIN_SPEED = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_stb,
    input  logic [15:0] wr_data,
    input  logic        pwm_busy,
    output logic [15:0] speed_out,
    output logic        speed_oe
);

    logic [15:0] r_spd;
    logic        r_pend;
    logic        r_oe;
    logic        w_fire;

    // ~r_oe covers the cycle before the stage raises busy
    assign w_fire = r_pend & ~pwm_busy & ~r_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spd  <= 16'(MIN_SPEED);
            r_pend <= 1'b0;
            r_oe   <= 1'b0;
        end else begin
            r_oe <= 1'b0;
            if (wr_stb) begin
                r_spd  <= wr_data;
                r_pend <= 1'b1;
            end else if (w_fire) begin
                r_oe   <= 1'b1;
                r_pend <= 1'b0;
            end
        end
    end

    assign speed_out = r_spd;
    assign speed_oe  = r_oe;

endmodule

// File: rtl/motor_mixer.sv
// Quad-X mixer: one command in, four clamped speeds out through one
// shared adder. Optional arm input enabled by MOTOR_MIXER_ARM_EN.
module motor_mixer
    import motor_pkg::*;
#(
    parameter int MAX_SPEED  = 65535,
    parameter int MIN_SPEED  = 256,
    parameter int CORR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  throttle,
    input  logic signed [CORR_WIDTH-1:0] roll,
    input  logic signed [CORR_WIDTH-1:0] pitch,
    input  logic signed [CORR_WIDTH-1:0] yaw,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic [15:0]                  speed_out [NUM_MOTORS],
    output logic [NUM_MOTORS-1:0]        speed_oe,
`ifdef MOTOR_MIXER_ARM_EN
    input  logic                         arm,
`endif
    input  logic [NUM_MOTORS-1:0]        pwm_busy
);

    localparam logic signed [MIX_W-1:0] LO = MIX_W'(MIN_SPEED);
    localparam logic signed [MIX_W-1:0] HI = MIX_W'(MAX_SPEED);

    state_t                       r_state;
    state_t                       w_next;
    logic [1:0]                   r_idx;
    logic [15:0]                  r_thr;
    logic signed [CORR_WIDTH-1:0] r_roll;
    logic signed [CORR_WIDTH-1:0] r_pitch;
    logic signed [CORR_WIDTH-1:0] r_yaw;
    logic                         w_acc;
    logic                         w_calc;
    logic signed [MIX_W-1:0]      w_t;
    logic signed [MIX_W-1:0]      w_r;
    logic signed [MIX_W-1:0]      w_p;
    logic signed [MIX_W-1:0]      w_y;
    logic [2:0]                   w_neg;
    logic signed [MIX_W-1:0]      w_sum;
    logic [15:0]                  w_clamp;
    logic [15:0]                  w_val;
    logic                         w_armed;
    logic                         w_fall;
    logic [NUM_MOTORS-1:0]        w_hit;
    logic [NUM_MOTORS-1:0]        w_wr;
    logic [15:0]                  w_wd [NUM_MOTORS];

    assign w_acc = cmd_valid & cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_acc) w_next = CALC;
            CALC: if (r_idx == 2'd3) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        w_calc    = (r_state == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_thr   <= '0;
            r_roll  <= '0;
            r_pitch <= '0;
            r_yaw   <= '0;
        end else if (w_acc) begin
            r_idx   <= 2'd0;
            r_thr   <= throttle;
            r_roll  <= roll;
            r_pitch <= pitch;
            r_yaw   <= yaw;
        end else if (w_calc) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    assign w_t = $signed({{(MIX_W-16){1'b0}}, r_thr});
    assign w_r = {{(MIX_W-CORR_WIDTH){r_roll[CORR_WIDTH-1]}}, r_roll};
    assign w_p = {{(MIX_W-CORR_WIDTH){r_pitch[CORR_WIDTH-1]}}, r_pitch};
    assign w_y = {{(MIX_W-CORR_WIDTH){r_yaw[CORR_WIDTH-1]}}, r_yaw};

    assign w_neg = MIX_NEG[r_idx];
    assign w_sum = w_t
                 + mix_term(w_r, w_neg[0])
                 + mix_term(w_p, w_neg[1])
                 + mix_term(w_y, w_neg[2]);

    always_comb begin
        w_clamp = w_sum[15:0];
        if (w_sum < LO) begin
            w_clamp = 16'(MIN_SPEED);
        end else if (w_sum > HI) begin
            w_clamp = 16'(MAX_SPEED);
        end
    end

`ifdef MOTOR_MIXER_ARM_EN
    logic r_arm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_q <= 1'b0;
        end else begin
            r_arm_q <= arm;
        end
    end

    assign w_armed = arm;
    assign w_fall  = r_arm_q & ~arm;
`else
    assign w_armed = 1'b1;
    assign w_fall  = 1'b0;
`endif

    assign w_val = w_armed ? w_clamp : 16'(MIN_SPEED);

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
        // a CALC write beats a disarm spin-down on the same channel
        assign w_hit[i] = w_calc && (r_idx == 2'(i));
        assign w_wr[i]  = w_hit[i] | w_fall;
        assign w_wd[i]  = w_hit[i] ? w_val : 16'(MIN_SPEED);

        motor_dispatch #(
            .MIN_SPEED (MIN_SPEED)
        ) u_disp (
            .clk       (clk),
            .rst       (rst),
            .wr_stb    (w_wr[i]),
            .wr_data   (w_wd[i]),
            .pwm_busy  (pwm_busy[i]),
            .speed_out (speed_out[i]),
            .speed_oe  (speed_oe[i])
        );
    end

endmodule

// File: tb/tb_motor_mixer.sv
// Randomized and directed bench for motor_mixer with a behavioural
// mixing model and strobe monitor.
module tb_motor_mixer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        throttle = '0;
    logic signed [15:0] roll = '0;
    logic signed [15:0] pitch = '0;
    logic signed [15:0] yaw = '0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [15:0]        speed_out [4];
    logic [3:0]         speed_oe;
    logic [3:0]         pwm_busy;
    logic [3:0]         busy_force = '0;
    logic [3:0]         busy_lat = '0;
    logic               pwm_model = 1'b0;
`ifdef MOTOR_MIXER_ARM_EN
    logic               arm = 1'b1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int cnt [4] = '{0, 0, 0, 0};
    int lastv [4] = '{0, 0, 0, 0};
    int lastc [4] = '{0, 0, 0, 0};
    int wide [4] = '{0, 0, 0, 0};
    int bcnt [4];
    int bwide [4];
    logic [3:0] prev_oe = '0;
    int lt, lr, lp, ly;

    motor_mixer dut (
        .clk       (clk),
        .rst       (rst),
        .throttle  (throttle),
        .roll      (roll),
        .pitch     (pitch),
        .yaw       (yaw),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .speed_out (speed_out),
        .speed_oe  (speed_oe),
`ifdef MOTOR_MIXER_ARM_EN
        .arm       (arm),
`endif
        .pwm_busy  (pwm_busy)
    );

    always #5 clk = ~clk;

    always_comb pwm_busy = busy_force | busy_lat;

    // PWM stage model: busy rises the edge after a strobe and sticks
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!pwm_model) busy_lat <= '0;
        else busy_lat <= busy_lat | speed_oe;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (speed_oe[i]) begin
                cnt[i]   <= cnt[i] + 1;
                lastv[i] <= int'(speed_out[i]);
                lastc[i] <= cyc;
                if (prev_oe[i]) wide[i] <= wide[i] + 1;
            end
        end
        prev_oe <= speed_oe;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mix(input int t, input int r, input int p,
                               input int y, input int m);
        int v;
        case (m)
            0:       v = t + r + p - y;
            1:       v = t - r + p + y;
            2:       v = t - r - p - y;
            default: v = t + r - p + y;
        endcase
        if (v < 256) v = 256;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            bcnt[i]  = cnt[i];
            bwide[i] = wide[i];
        end
    endtask

    task automatic send(input int t, input int r, input int p, input int y);
        int n;
        n = 0;
        @(negedge clk);
        throttle  = 16'(t);
        roll      = 16'(r);
        pitch     = 16'(p);
        yaw       = 16'(y);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            cmd_valid = 1'b0;
            lt = t; lr = r; lp = p; ly = y;
        end
    endtask

    task automatic chk_vals(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_m%0d", tag, i), int'(speed_out[i]),
                mix(lt, lr, lp, ly, i));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r, p, y;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitc(1);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_oe", int'(speed_oe), 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_spd%0d", i), int'(speed_out[i]), 256);

        // basic command and strobe timing
        snap();
        send(20000, 1000, -500, 200);
        waitc(8);
        chk_vals("basic");
        chk("basic_m0", int'(speed_out[0]), 20300);
        chk("basic_m3", int'(speed_out[3]), 21700);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_cnt%0d", i), cnt[i] - bcnt[i], 1);
            chk($sformatf("basic_lat%0d", i), lastc[i] - acc, 2 + i);
            chk($sformatf("basic_sv%0d", i), lastv[i],
                mix(lt, lr, lp, ly, i));
        end

        // clamping
        send(300, -2000, 0, 0);
        waitc(8);
        chk_vals("lo");
        chk("lo_m0", int'(speed_out[0]), 256);
        chk("lo_m1", int'(speed_out[1]), 2300);
        send(65000, 1000, 1000, 1000);
        waitc(8);
        chk_vals("hi");
        chk("hi_m1", int'(speed_out[1]), 65535);
        chk("hi_m3", int'(speed_out[3]), 65535);

        // latest wins while busy held
        busy_force = 4'b0100;
        snap();
        send(10000, 0, 0, 0);
        waitc(6);
        send(12000, 0, 0, 0);
        waitc(8);
        chk("hold_cnt2", cnt[2] - bcnt[2], 0);
        chk("hold_cnt0", cnt[0] - bcnt[0], 2);
        busy_force = 4'b0000;
        waitc(5);
        chk("rel_cnt2", cnt[2] - bcnt[2], 1);
        chk("rel_val2", lastv[2], 12000);

        // sticky busy model: single-cycle strobes only
        pwm_model = 1'b1;
        snap();
        send(15000, 300, -700, 900);
        waitc(8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pwm_cnt%0d", i), cnt[i] - bcnt[i], 1);
            chk($sformatf("pwm_wide%0d", i), wide[i] - bwide[i], 0);
        end
        chk("pwm_busy", int'(pwm_busy), 15);
        send(25000, -100, 50, 0);
        waitc(8);
        chk("pwm_stuck0", cnt[0] - bcnt[0], 1);
        chk("pwm_stuck3", cnt[3] - bcnt[3], 1);
        pwm_model = 1'b0;
        waitc(6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pwm_rel%0d", i), cnt[i] - bcnt[i], 2);
            chk($sformatf("pwm_rv%0d", i), lastv[i],
                mix(lt, lr, lp, ly, i));
        end

        // reset in the middle of CALC
        snap();
        send(40000, 100, 100, 100);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_oe", int'(speed_oe), 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mid_spd%0d", i), int'(speed_out[i]), 256);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitc(8);
        chk("mid_ready", int'(cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid_cnt%0d", i), cnt[i] - bcnt[i], 0);
            chk($sformatf("mid_hold%0d", i), int'(speed_out[i]), 256);
        end

        // randomized commands with random stuck-busy masks
        snap();
        for (int k = 0; k < 40; k++) begin
            busy_force = ($urandom_range(0, 1) == 1) ? 4'(
                $urandom_range(0, 15)) : 4'b0000;
            t = int'($urandom_range(0, 65535));
            r = int'($urandom_range(0, 65535)) - 32768;
            p = int'($urandom_range(0, 65535)) - 32768;
            y = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 1) == 1) begin
                r = r / 64; p = p / 64; y = y / 64;
            end
            send(t, r, p, y);
            waitc(5);
            chk_vals($sformatf("rnd%0d", k));
        end
        busy_force = 4'b0000;
        waitc(6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rnd_last%0d", i), lastv[i],
                mix(lt, lr, lp, ly, i));
            chk($sformatf("rnd_wide%0d", i), wide[i] - bwide[i], 0);
        end

`ifdef MOTOR_MIXER_ARM_EN
        arm = 1'b0;
        waitc(2);
        send(30000, 0, 0, 0);
        waitc(8);
        for (int i = 0; i < 4; i++)
            chk($sformatf("dis_spd%0d", i), int'(speed_out[i]), 256);
        arm = 1'b1;
        send(30000, 0, 0, 0);
        waitc(8);
        chk_vals("armed");
        snap();
        @(negedge clk);
        arm = 1'b0;
        waitc(6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fall_cnt%0d", i), cnt[i] - bcnt[i], 1);
            chk($sformatf("fall_val%0d", i), lastv[i], 256);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
